// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART controller's tx handshake: one single-cycle start
// pulse per frame, data held stable until the next launch, retry on a missed start.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mpi_uart_en,
  input  logic                  fifo_clr,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  ovf_err,
  output logic                  tx_busy,
  output logic                  usr_start_tx,
  output logic [7:0]            usr_data_tx,
  input  logic                  usr_done_tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);
  localparam logic [TMO_W-1:0]      TMO_ONE    = (TMO_W)'(1);
  localparam logic [TMO_W-1:0]      TMO_LIMIT  = (TMO_W)'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  ovf_q, ovf_d;
  state_t                state_q, state_d;
  logic                  start_q, start_d;
  logic [7:0]            data_q, data_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  flushed_q, flushed_d;

  logic full_w, empty_w;
  logic push, pop;

  assign full_w  = (level_q == LEVEL_FULL);
  assign empty_w = (level_q == '0);

  // A flush discards any coincident write, so it also suppresses the overflow flag.
  assign push = wr_en & ~full_w & ~fifo_clr;

  // Storage has no reset so it can map onto block RAM; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    data_d    = data_q;
    tmo_d     = tmo_q;
    flushed_d = flushed_q;
    pop       = 1'b0;

    // A flush during a frame lets the frame finish but forbids its pop.
    if (fifo_clr && (state_q != S_IDLE)) begin
      flushed_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!empty_w && mpi_uart_en && usr_done_tx && !fifo_clr) begin
          start_d   = 1'b1;
          data_d    = mem_q[rd_ptr_q];
          tmo_d     = '0;
          flushed_d = 1'b0;
          state_d   = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!usr_done_tx) begin
          state_d = S_WAIT_DONE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
          if (tmo_d == TMO_LIMIT) begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (usr_done_tx) begin
          pop     = ~flushed_q & ~fifo_clr;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        level_d = level_q + LEVEL_ONE;
      end else if (pop && !push) begin
        level_d = level_q - LEVEL_ONE;
      end
      if (wr_en && full_w) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      data_q    <= 8'h00;
      tmo_q     <= '0;
      flushed_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      start_q   <= start_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      flushed_q <= flushed_d;
    end
  end

  assign full         = full_w;
  assign empty        = empty_w;
  assign fifo_level   = level_q;
  assign ovf_err      = ovf_q;
  assign tx_busy      = (state_q != S_IDLE);
  assign usr_start_tx = start_q;
  assign usr_data_tx  = data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a small controller model answers start pulses,
// a negedge monitor records launched bytes and pulse/stability violations.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       mpi_uart_en;
  logic       fifo_clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] fifo_level;
  logic       ovf_err;
  logic       tx_busy;
  logic       usr_start_tx;
  logic [7:0] usr_data_tx;
  logic       usr_done_tx;

  int checks;
  int failures;

  logic [7:0] sent_q[$];
  int         start_cnt;
  int         wide_pulse;
  int         unstable;
  logic       prev_start;
  logic [7:0] cur_byte;
  bit         ctrl_en;

  uart_tx_fifo #(.DEPTH_LOG2(4), .BUSY_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mpi_uart_en (mpi_uart_en),
    .fifo_clr    (fifo_clr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .fifo_level  (fifo_level),
    .ovf_err     (ovf_err),
    .tx_busy     (tx_busy),
    .usr_start_tx(usr_start_tx),
    .usr_data_tx (usr_data_tx),
    .usr_done_tx (usr_done_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Monitor: one record per rising start pulse.
  initial begin
    prev_start = 1'b0;
    cur_byte   = 8'h00;
    forever begin
      @(negedge clk);
      if (usr_start_tx && !prev_start) begin
        start_cnt++;
        sent_q.push_back(usr_data_tx);
        cur_byte = usr_data_tx;
        $display("tx frame %0d: data=0x%02h", start_cnt, usr_data_tx);
      end
      if (usr_start_tx && prev_start) wide_pulse++;
      if (!usr_done_tx && !rst && (usr_data_tx !== cur_byte)) unstable++;
      prev_start = usr_start_tx;
    end
  end

  // Controller model: busy for 6 cycles after each start it sees.
  initial begin
    forever begin
      @(negedge clk);
      if (ctrl_en && usr_start_tx) begin
        usr_done_tx = 1'b0;
        repeat (6) @(negedge clk);
        usr_done_tx = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mpi_uart_en = 1'b0; fifo_clr = 1'b0; wr_en = 1'b0;
    wr_data = 8'h00; usr_done_tx = 1'b1; ctrl_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({full, empty, ovf_err, tx_busy, usr_start_tx} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=01000", {full, empty, ovf_err, tx_busy, usr_start_tx});
    end
    checks++;
    if (fifo_level !== 5'd0) begin
      failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level);
    end
    checks++;
    if (usr_data_tx !== 8'h00) begin
      failures++; $display("FAIL reset_data got=%02h exp=00", usr_data_tx);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] exp3 [3];
    logic [7:0] got;
    int b0, s0, w0, u0, n;
    exp3[0] = 8'h55; exp3[1] = 8'hA3; exp3[2] = 8'h0F;
    b0 = start_cnt; s0 = sent_q.size(); w0 = wide_pulse; u0 = unstable;
    ctrl_en = 1'b1; mpi_uart_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h55; tick();
    wr_data = 8'hA3; tick();
    wr_data = 8'h0F; tick();
    wr_en = 1'b0;
    for (n = 0; n < 500; n++) begin
      if ((start_cnt - b0 >= 3) && empty && !tx_busy) break;
      tick();
    end
    checks++;
    if (start_cnt - b0 != 3) begin
      failures++; $display("FAIL basic_start_count got=%0d exp=3", start_cnt - b0);
    end
    for (int k = 0; k < 3; k++) begin
      got = (sent_q.size() > s0 + k) ? sent_q[s0 + k] : 8'hxx;
      checks++;
      if (got !== exp3[k]) begin
        failures++; $display("FAIL basic_byte%0d got=%02h exp=%02h", k, got, exp3[k]);
      end
    end
    checks++;
    if (wide_pulse != w0) begin
      failures++; $display("FAIL basic_pulse_width wide_pulses=%0d exp=0", wide_pulse - w0);
    end
    checks++;
    if (unstable != u0) begin
      failures++; $display("FAIL basic_data_stable changes=%0d exp=0", unstable - u0);
    end
    checks++;
    if ({fifo_level, empty} !== {5'd0, 1'b1}) begin
      failures++; $display("FAIL basic_end_level level=%0d empty=%b exp level=0 empty=1", fifo_level, empty);
    end
    ctrl_en = 1'b0; mpi_uart_en = 1'b0;
    $display("test_basic done");
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    int b0, s0, n;
    ctrl_en = 1'b0; mpi_uart_en = 1'b0;
    b0 = start_cnt;
    for (int i = 0; i < 17; i++) begin
      write_byte(8'h10 + 8'(i));
      if (i == 15) begin
        checks++;
        if ({full, fifo_level, ovf_err} !== {1'b1, 5'd16, 1'b0}) begin
          failures++;
          $display("FAIL ovf_full_at16 full=%b level=%0d ovf=%b exp 1/16/0", full, fifo_level, ovf_err);
        end
      end
    end
    checks++;
    if ({ovf_err, full, fifo_level} !== {1'b1, 1'b1, 5'd16}) begin
      failures++;
      $display("FAIL ovf_after17 ovf=%b full=%b level=%0d exp 1/1/16", ovf_err, full, fifo_level);
    end
    tick(); tick(); tick();
    checks++;
    if (start_cnt != b0) begin
      failures++; $display("FAIL ovf_no_start_disabled starts=%0d exp=0", start_cnt - b0);
    end
    s0 = sent_q.size();
    ctrl_en = 1'b1; mpi_uart_en = 1'b1;
    for (n = 0; n < 400; n++) begin
      tick();
      if (empty && !tx_busy) break;
    end
    checks++;
    if (sent_q.size() - s0 != 16) begin
      failures++; $display("FAIL ovf_drain_count got=%0d exp=16", sent_q.size() - s0);
    end
    got = (sent_q.size() > s0) ? sent_q[s0] : 8'hxx;
    checks++;
    if (got !== 8'h10) begin
      failures++; $display("FAIL ovf_first_byte got=%02h exp=10", got);
    end
    got = (sent_q.size() > s0 + 15) ? sent_q[s0 + 15] : 8'hxx;
    checks++;
    if (got !== 8'h1F) begin
      failures++; $display("FAIL ovf_last_byte got=%02h exp=1f", got);
    end
    checks++;
    if (ovf_err !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err);
    end
    ctrl_en = 1'b0; mpi_uart_en = 1'b0;
    $display("test_overflow done");
  endtask

  task automatic test_full_pop();
    logic [7:0] got;
    bit ok;
    int s0, n;
    fifo_clr = 1'b1; tick(); fifo_clr = 1'b0;
    checks++;
    if ({ovf_err, fifo_level} !== {1'b0, 5'd0}) begin
      failures++; $display("FAIL fullpop_clr ovf=%b level=%0d exp 0/0", ovf_err, fifo_level);
    end
    for (int i = 0; i < 16; i++) write_byte(8'h30 + 8'(i));
    s0 = sent_q.size();
    mpi_uart_en = 1'b1;
    ok = 1'b0;
    for (n = 0; n < 10; n++) begin
      tick();
      if (usr_start_tx) begin ok = 1'b1; break; end
    end
    usr_done_tx = 1'b0;
    checks++;
    if (!ok || usr_data_tx !== 8'h30) begin
      failures++; $display("FAIL fullpop_launch started=%b data=%02h exp 1/30", ok, usr_data_tx);
    end
    tick();
    checks++;
    if (fifo_level !== 5'd16) begin
      failures++; $display("FAIL fullpop_level_inflight got=%0d exp=16", fifo_level);
    end
    usr_done_tx = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; mpi_uart_en = 1'b0;
    tick();
    wr_en = 1'b0;
    checks++;
    if ({fifo_level, ovf_err, full} !== {5'd15, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL fullpop_same_cycle level=%0d ovf=%b full=%b exp 15/1/0", fifo_level, ovf_err, full);
    end
    ctrl_en = 1'b1; mpi_uart_en = 1'b1;
    for (n = 0; n < 400; n++) begin
      tick();
      if (empty && !tx_busy) break;
    end
    got = (sent_q.size() > 0) ? sent_q[sent_q.size() - 1] : 8'hxx;
    checks++;
    if (sent_q.size() - s0 != 16 || got !== 8'h3F) begin
      failures++;
      $display("FAIL fullpop_drain count=%0d last=%02h exp 16/3f", sent_q.size() - s0, got);
    end
    ctrl_en = 1'b0; mpi_uart_en = 1'b0;
    $display("test_full_pop done");
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    usr_done_tx = 1'b1;
    write_byte(8'h77);
    mpi_uart_en = 1'b1;
    ok = 1'b0;
    for (n = 0; n < 10; n++) begin
      tick();
      if (usr_start_tx) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || usr_data_tx !== 8'h77) begin
      failures++; $display("FAIL timeout_launch started=%b data=%02h exp 1/77", ok, usr_data_tx);
    end
    for (n = 1; n <= 20; n++) begin
      tick();
      if (!tx_busy) break;
    end
    checks++;
    if (n != 4) begin
      failures++; $display("FAIL timeout_cycles got=%0d exp=4", n);
    end
    checks++;
    if (fifo_level !== 5'd1) begin
      failures++; $display("FAIL timeout_no_pop level=%0d exp=1", fifo_level);
    end
    tick();
    checks++;
    if ({usr_start_tx, usr_data_tx} !== {1'b1, 8'h77}) begin
      failures++; $display("FAIL timeout_relaunch start=%b data=%02h exp 1/77", usr_start_tx, usr_data_tx);
    end
    usr_done_tx = 1'b0;
    tick(); tick();
    usr_done_tx = 1'b1;
    tick();
    checks++;
    if ({fifo_level, empty} !== {5'd0, 1'b1}) begin
      failures++; $display("FAIL timeout_final_pop level=%0d empty=%b exp 0/1", fifo_level, empty);
    end
    mpi_uart_en = 1'b0;
    $display("test_timeout done");
  endtask

  task automatic test_flush();
    bit ok;
    int n, s;
    for (int i = 0; i < 5; i++) write_byte(8'h40 + 8'(i));
    mpi_uart_en = 1'b1;
    ok = 1'b0;
    for (n = 0; n < 10; n++) begin
      tick();
      if (usr_start_tx) begin ok = 1'b1; break; end
    end
    usr_done_tx = 1'b0;
    checks++;
    if (!ok || usr_data_tx !== 8'h40) begin
      failures++; $display("FAIL flush_launch started=%b data=%02h exp 1/40", ok, usr_data_tx);
    end
    tick(); tick();
    fifo_clr = 1'b1; tick(); fifo_clr = 1'b0;
    checks++;
    if ({fifo_level, empty, tx_busy} !== {5'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL flush_clear level=%0d empty=%b busy=%b exp 0/1/1", fifo_level, empty, tx_busy);
    end
    tick(); tick();
    usr_done_tx = 1'b1;
    tick();
    checks++;
    if ({fifo_level, tx_busy} !== {5'd0, 1'b0}) begin
      failures++; $display("FAIL flush_complete level=%0d busy=%b exp 0/0", fifo_level, tx_busy);
    end
    s = start_cnt;
    tick(); tick(); tick();
    checks++;
    if (start_cnt != s || fifo_level !== 5'd0) begin
      failures++; $display("FAIL flush_idle starts=%0d level=%0d exp 0/0", start_cnt - s, fifo_level);
    end
    mpi_uart_en = 1'b0;
    $display("test_flush done");
  endtask

  task automatic test_rst_midframe();
    bit ok;
    int n, s;
    write_byte(8'h60); write_byte(8'h61); write_byte(8'h62);
    mpi_uart_en = 1'b1;
    for (n = 0; n < 10; n++) begin
      tick();
      if (usr_start_tx) break;
    end
    usr_done_tx = 1'b0;
    tick(); tick();
    checks++;
    if ({tx_busy, usr_data_tx} !== {1'b1, 8'h60}) begin
      failures++; $display("FAIL rstmid_inflight busy=%b data=%02h exp 1/60", tx_busy, usr_data_tx);
    end
    rst = 1'b1; usr_done_tx = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({full, empty, ovf_err, tx_busy, usr_start_tx, fifo_level, usr_data_tx} !==
        {5'b01000, 5'd0, 8'h00}) begin
      failures++;
      $display("FAIL rstmid_outputs flags=%b level=%0d data=%02h exp 01000/0/00",
               {full, empty, ovf_err, tx_busy, usr_start_tx}, fifo_level, usr_data_tx);
    end
    s = start_cnt;
    repeat (5) tick();
    checks++;
    if (start_cnt != s || tx_busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_start starts=%0d busy=%b exp 0/0", start_cnt - s, tx_busy);
    end
    write_byte(8'h99);
    ok = usr_start_tx;
    for (n = 0; n < 10 && !ok; n++) begin
      tick();
      ok = usr_start_tx;
    end
    checks++;
    if (!ok || usr_data_tx !== 8'h99) begin
      failures++; $display("FAIL rstmid_new_launch started=%b data=%02h exp 1/99", ok, usr_data_tx);
    end
    usr_done_tx = 1'b0; tick();
    usr_done_tx = 1'b1; tick();
    mpi_uart_en = 1'b0;
    $display("test_rst_midframe done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_flush();
    test_rst_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit buffer that sits directly upstream of the UART controller. It accepts bytes from the CPU/user side into a DEPTH-entry FIFO.
- It drains the FIFO one frame at a time through the controller's tx handshake (usr_start_tx / usr_data_tx / usr_done_tx).
- It guarantees a single-cycle start pulse and holds data stable for the whole frame. Software never has to poll frame completion per byte.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries of 8 bits.
- BUSY_TIMEOUT, 4, max cycles to wait for usr_done_tx to fall after a start pulse before retrying.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- mpi_uart_en  in  1  UART enable; frames are launched only while 1
- fifo_clr  in  1  synchronous flush of FIFO contents and the overflow flag
- wr_en  in  1  write strobe, one byte per cycle
- wr_data  in  8  byte to enqueue
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- fifo_level  out  DEPTH_LOG2+1  current entry count
- ovf_err  out  1  sticky: a write was attempted while full
- tx_busy  out  1  FSM not in S_IDLE
- usr_start_tx  out  1  to controller: one-cycle start pulse
- usr_data_tx  out  8  to controller: byte being sent, held for the whole frame
- usr_done_tx  in  1  from controller: level, 1 = transmitter idle

Behaviour:
- Reset values: full=0, empty=1, fifo_level=0, ovf_err=0, tx_busy=0, usr_start_tx=0, usr_data_tx=8'h00. Internal state: wr_ptr=rd_ptr=0, state=S_IDLE.
- All outputs are registered. full and empty are decoded from the registered level.

Write path:
- wr_en & !full: mem[wr_ptr]<=wr_data, wr_ptr++ (wraps modulo DEPTH).
- wr_en & full: data dropped, pointers unchanged, ovf_err<=1.
- full is evaluated on the current level. A write in the same cycle as a pop while full is still dropped.
- Push and pop in the same cycle: fifo_level unchanged, both pointers advance.

FSM states:
- S_IDLE
  - Launch condition: !empty & mpi_uart_en & usr_done_tx & !fifo_clr.
  - On launch: usr_start_tx<=1, usr_data_tx<=mem[rd_ptr], timeout counter<=0, go to S_WAIT_BUSY.
- S_WAIT_BUSY
  - usr_start_tx<=0, so the start pulse is exactly one cycle wide.
  - usr_done_tx==0: go to S_WAIT_DONE.
  - Else the counter increments. When it reaches BUSY_TIMEOUT (controller disabled or ignored the start), return to S_IDLE with no pop; the entry is retried later.
- S_WAIT_DONE
  - Wait for usr_done_tx==1.
  - Then pop (rd_ptr++, level--) unless the frame was flushed, and go to S_IDLE.
  - The next launch can occur on the following cycle.
- usr_data_tx changes only on a launch. It is stable from the start pulse until the next launch.

fifo_clr:
- Next cycle: wr_ptr=rd_ptr=0, level=0, ovf_err=0.
- A write coinciding with fifo_clr is discarded.
- A frame already launched is not aborted. The FSM sets a flushed flag, finishes S_WAIT_DONE, and skips the pop.

Other rules:
- If mpi_uart_en drops mid-frame, the FSM still tracks usr_done_tx normally.
- rst mid-frame returns every register to its reset value immediately. Buffered data is lost.
- fifo_level arithmetic is DEPTH_LOG2+1 bits wide and never exceeds DEPTH.

Test Plan:
1. Write 0x55, 0xA3, 0x0F back-to-back with the controller model, en=1 → three start pulses, each exactly 1 cycle wide; usr_data_tx = 0x55, 0xA3, 0x0F in order and stable while usr_done_tx=0; ends with fifo_level=0, empty=1.
2. Write 17 bytes with en=0 (DEPTH=16) → full=1 after the 16th; the 17th is dropped and ovf_err=1; no usr_start_tx; the first byte transmitted after en=1 is byte 0.
3. Stub holds usr_done_tx=1 (ignores start) → after BUSY_TIMEOUT cycles the FSM returns to S_IDLE, fifo_level unchanged, the same byte is relaunched.
4. With level=16, write in the same cycle the pop occurs → write dropped, ovf_err=1, level=15 afterwards.
5. fifo_clr asserted during S_WAIT_DONE with 5 entries → level=0 next cycle; the frame completes; no pop underflow; level stays 0; tx_busy falls when usr_done_tx rises.
6. Assert rst during S_WAIT_DONE → next cycle all outputs are at reset values and empty=1; no start pulse until a new write.
